// File: rtl/mm_axi_lite_master.sv
// mm_axi_lite_master: single-outstanding AXI4-Lite initiator fed by a cmd/rsp valid-ready port pair
module mm_axi_lite_master #(
  parameter int C_M0_axi_DATA_WIDTH = 32,
  parameter int C_M0_axi_ADDR_WIDTH = 4
) (
  input  logic                               M0_axi_aclk,
  input  logic                               M0_axi_aresetn,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic                               cmd_write,
  input  logic [C_M0_axi_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M0_axi_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M0_axi_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [C_M0_axi_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                         rsp_resp,
  output logic [C_M0_axi_ADDR_WIDTH-1:0]     M0_axi_awaddr,
  output logic [2:0]                         M0_axi_awprot,
  output logic                               M0_axi_awvalid,
  input  logic                               M0_axi_awready,
  output logic [C_M0_axi_DATA_WIDTH-1:0]     M0_axi_wdata,
  output logic [C_M0_axi_DATA_WIDTH/8-1:0]   M0_axi_wstrb,
  output logic                               M0_axi_wvalid,
  input  logic                               M0_axi_wready,
  input  logic [1:0]                         M0_axi_bresp,
  input  logic                               M0_axi_bvalid,
  output logic                               M0_axi_bready,
  output logic [C_M0_axi_ADDR_WIDTH-1:0]     M0_axi_araddr,
  output logic [2:0]                         M0_axi_arprot,
  output logic                               M0_axi_arvalid,
  input  logic                               M0_axi_arready,
  input  logic [C_M0_axi_DATA_WIDTH-1:0]     M0_axi_rdata,
  input  logic [1:0]                         M0_axi_rresp,
  input  logic                               M0_axi_rvalid,
  output logic                               M0_axi_rready
);
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;
  state_t state, state_nxt;
  logic accept;
  assign accept = cmd_valid & cmd_ready;
  assign M0_axi_awprot = 3'b000;
  assign M0_axi_arprot = 3'b000;
  // state register
  always_ff @(posedge M0_axi_aclk or negedge M0_axi_aresetn) begin
    if (!M0_axi_aresetn) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: the write phase ends once both AW and W have handshaken, in either order or together
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = cmd_valid ? (cmd_write ? WADDR : RADDR) : IDLE;
      WADDR:   state_nxt = ((!M0_axi_awvalid || M0_axi_awready) && (!M0_axi_wvalid || M0_axi_wready)) ? WRESP : WADDR;
      WRESP:   state_nxt = M0_axi_bvalid ? RSP : WRESP;
      RADDR:   state_nxt = M0_axi_arready ? RDATA : RADDR;
      RDATA:   state_nxt = M0_axi_rvalid ? RSP : RDATA;
      RSP:     state_nxt = rsp_ready ? IDLE : RSP;
      default: state_nxt = IDLE;
    endcase
  end
  // state-decoded handshake outputs
  always_comb begin
    cmd_ready     = state == IDLE;
    M0_axi_bready = state == WRESP;
    M0_axi_rready = state == RDATA;
    rsp_valid     = state == RSP;
  end
  // request channels: loaded on acceptance, each valid drops on its own handshake
  always_ff @(posedge M0_axi_aclk or negedge M0_axi_aresetn) begin
    if (!M0_axi_aresetn) begin
      M0_axi_awvalid <= 1'b0;
      M0_axi_wvalid  <= 1'b0;
      M0_axi_arvalid <= 1'b0;
      M0_axi_awaddr  <= '0;
      M0_axi_wdata   <= '0;
      M0_axi_wstrb   <= '0;
      M0_axi_araddr  <= '0;
    end else begin
      if (accept && cmd_write) begin
        M0_axi_awvalid <= 1'b1;
        M0_axi_wvalid  <= 1'b1;
        M0_axi_awaddr  <= cmd_addr;
        M0_axi_wdata   <= cmd_wdata;
        M0_axi_wstrb   <= cmd_wstrb;
      end else begin
        if (M0_axi_awready) M0_axi_awvalid <= 1'b0;
        if (M0_axi_wready) M0_axi_wvalid <= 1'b0;
      end
      if (accept && !cmd_write) begin
        M0_axi_arvalid <= 1'b1;
        M0_axi_araddr  <= cmd_addr;
      end else if (M0_axi_arready) begin
        M0_axi_arvalid <= 1'b0;
      end
    end
  end
  // response capture: B and R are only looked at in the state that expects them
  always_ff @(posedge M0_axi_aclk or negedge M0_axi_aresetn) begin
    if (!M0_axi_aresetn) begin
      rsp_rdata <= '0;
      rsp_resp  <= 2'b00;
    end else if (state == WRESP && M0_axi_bvalid) begin
      rsp_rdata <= '0;
      rsp_resp  <= M0_axi_bresp;
    end else if (state == RDATA && M0_axi_rvalid) begin
      rsp_rdata <= M0_axi_rdata;
      rsp_resp  <= M0_axi_rresp;
    end
  end
endmodule

// File: tb/tb_mm_axi_lite_master.sv
// tb_mm_axi_lite_master: directed and randomized checks of the AXI4-Lite initiator against a word-level memory model
module tb_mm_axi_lite_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [3:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, wvalid, arvalid, bready, rready;
  logic awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
  logic [31:0] wdata, rdata = '0;
  logic [3:0] wstrb;
  logic [1:0] bresp = '0, rresp = '0;

  mm_axi_lite_master #(.C_M0_axi_DATA_WIDTH(32), .C_M0_axi_ADDR_WIDTH(4)) dut (
    .M0_axi_aclk(clk), .M0_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M0_axi_awaddr(awaddr), .M0_axi_awprot(awprot), .M0_axi_awvalid(awvalid), .M0_axi_awready(awready),
    .M0_axi_wdata(wdata), .M0_axi_wstrb(wstrb), .M0_axi_wvalid(wvalid), .M0_axi_wready(wready),
    .M0_axi_bresp(bresp), .M0_axi_bvalid(bvalid), .M0_axi_bready(bready),
    .M0_axi_araddr(araddr), .M0_axi_arprot(arprot), .M0_axi_arvalid(arvalid), .M0_axi_arready(arready),
    .M0_axi_rdata(rdata), .M0_axi_rresp(rresp), .M0_axi_rvalid(rvalid), .M0_axi_rready(rready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  bit r_force = 1'b0;
  logic [31:0] r_force_data = '0;
  bit rsp_tie = 1'b0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, unstable = 0;
  logic [31:0] smem [4] = '{default: 32'h0};
  logic [31:0] mdl [4] = '{default: 32'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave: ready after a programmed wait, B/R after a programmed delay, word memory behind it
  initial begin
    bit p_aw, p_w, p_ar, p_b, p_r, got_aw, got_w, b_pend, r_pend, hs_aw, hs_w, hs_ar;
    logic [3:0] p_awaddr, p_araddr, s_awaddr, p_wstrb, s_wstrb;
    logic [31:0] p_wdata, s_wdata, s_rdata;
    int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
    p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0; got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
    p_awaddr = 0; p_araddr = 0; s_awaddr = 0; p_wstrb = 0; s_wstrb = 0; p_wdata = 0; s_wdata = 0; s_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
        p_aw = 0; p_w = 0; p_ar = 0; p_b = 0; p_r = 0; got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        hs_aw = p_aw && awready;
        hs_w  = p_w && wready;
        hs_ar = p_ar && arready;
        if (p_aw && !hs_aw && (!awvalid || awaddr !== p_awaddr)) unstable++;
        if (p_w && !hs_w && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) unstable++;
        if (p_ar && !hs_ar && (!arvalid || araddr !== p_araddr)) unstable++;
        if (hs_aw) begin got_aw = 1; s_awaddr = p_awaddr; aw_hs++; end
        if (hs_w) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; w_hs++; end
        if (hs_ar) begin
          ar_hs++; r_pend = 1; r_wait = r_delay;
          s_rdata = r_force ? r_force_data : smem[p_araddr[3:2]];
        end
        if (p_b && bvalid) begin bvalid = 0; bresp = 0; b_hs++; end
        if (p_r && rvalid) begin rvalid = 0; rresp = 0; rdata = 0; r_hs++; end
        if (got_aw && got_w) begin
          for (int i = 0; i < 4; i++) if (s_wstrb[i]) smem[s_awaddr[3:2]][8*i +: 8] = s_wdata[8*i +: 8];
          got_aw = 0; got_w = 0; b_pend = 1; b_wait = b_delay;
        end
        if (b_pend) begin
          if (b_wait == 0) begin bvalid = 1; bresp = b_resp_cfg; b_pend = 0; end
          else b_wait--;
        end
        if (r_pend) begin
          if (r_wait == 0) begin rvalid = 1; rresp = r_resp_cfg; rdata = s_rdata; r_pend = 0; end
          else r_wait--;
        end
        awready = awvalid && aw_cnt == aw_delay; aw_cnt = awvalid ? aw_cnt + 1 : 0;
        wready  = wvalid && w_cnt == w_delay;    w_cnt  = wvalid ? w_cnt + 1 : 0;
        arready = arvalid && ar_cnt == ar_delay; ar_cnt = arvalid ? ar_cnt + 1 : 0;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (arvalid) ar_hi++;
        p_aw = awvalid; p_awaddr = awaddr; p_w = wvalid; p_wdata = wdata; p_wstrb = wstrb;
        p_ar = arvalid; p_araddr = araddr; p_b = bready; p_r = rready;
      end
    end
  end

  // one command end to end; call at a negedge with the block idle, returns at a negedge
  task automatic run_cmd(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    logic [31:0] exp_rd;
    logic [1:0] exp_resp;
    int exp_lat, lat, aw0, w0, b0, ar0, r0, awh0, wh0, arh0;
    if (wr) begin
      for (int i = 0; i < 4; i++) if (s[i]) mdl[a[3:2]][8*i +: 8] = d[8*i +: 8];
      exp_rd = 0; exp_resp = b_resp_cfg;
      exp_lat = 3 + (aw_delay > w_delay ? aw_delay : w_delay) + b_delay;
    end else begin
      exp_rd = r_force ? r_force_data : mdl[a[3:2]]; exp_resp = r_resp_cfg;
      exp_lat = 3 + ar_delay + r_delay;
    end
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs; awh0 = aw_hi; wh0 = w_hi; arh0 = ar_hi;
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    lat = 1;
    cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    while (!rsp_valid && lat < 60) begin @(negedge clk); lat++; end
    chk("rsp_valid", {31'b0, rsp_valid}, 1);
    chk("rsp_latency", lat, exp_lat);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, exp_resp});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_resp", {30'b0, rsp_resp}, {30'b0, exp_resp});
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 0);
    end
    rsp_ready = 1; cmd_valid = 0;
    @(negedge clk);
    rsp_ready = rsp_tie;
    chk("cmd_ready_after", {31'b0, cmd_ready}, 1);
    chk("rsp_valid_after", {31'b0, rsp_valid}, 0);
    chk("aw_count", aw_hs - aw0, wr ? 1 : 0);
    chk("w_count", w_hs - w0, wr ? 1 : 0);
    chk("b_count", b_hs - b0, wr ? 1 : 0);
    chk("ar_count", ar_hs - ar0, wr ? 0 : 1);
    chk("r_count", r_hs - r0, wr ? 0 : 1);
    chk("aw_high_cycles", aw_hi - awh0, wr ? aw_delay + 1 : 0);
    chk("w_high_cycles", w_hi - wh0, wr ? w_delay + 1 : 0);
    chk("ar_high_cycles", ar_hi - arh0, wr ? 0 : ar_delay + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'b0, awvalid}, 0);
    chk("rst_wvalid", {31'b0, wvalid}, 0);
    chk("rst_arvalid", {31'b0, arvalid}, 0);
    chk("rst_bready", {31'b0, bready}, 0);
    chk("rst_rready", {31'b0, rready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_addr", {24'b0, awaddr, araddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", {28'b0, wstrb}, 0);
    chk("rst_rsp", rsp_rdata | {30'b0, rsp_resp}, 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, cmd_ready}, 1);
    chk("prot", {26'b0, awprot, arprot}, 0);
    // zero-wait write
    run_cmd(1, 4'h4, 32'h0000_1234, 4'hF, 0);
    // delayed AW, immediate W
    aw_delay = 3;
    run_cmd(1, 4'hC, 32'hCAFE_F00D, 4'h5, 0);
    aw_delay = 0;
    chk("payload_stable", unstable, 0);
    // read with wait and error response
    r_delay = 4; r_resp_cfg = 2'b10; r_force = 1; r_force_data = 32'hDEAD_BEEF;
    run_cmd(0, 4'h8, 32'h0, 4'h0, 0);
    r_delay = 0; r_resp_cfg = 2'b00; r_force = 0;
    // response backpressure with a competing command
    b_resp_cfg = 2'b01;
    run_cmd(1, 4'h0, 32'h1357_9BDF, 4'hF, 10);
    b_resp_cfg = 2'b00;
    run_cmd(0, 4'hC, 32'h0, 4'h0, 10);
    // reset while AW is outstanding
    aw_delay = 6;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'hAAAA_5555; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("pre_reset_awvalid", {31'b0, awvalid}, 1);
    #3 rst_n = 0;
    #1;
    chk("async_awvalid", {31'b0, awvalid}, 0);
    chk("async_wvalid", {31'b0, wvalid}, 0);
    chk("async_bready", {31'b0, bready}, 0);
    chk("async_rsp_valid", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    aw_delay = 0;
    @(negedge clk);
    chk("ready_after_mid_reset", {31'b0, cmd_ready}, 1);
    run_cmd(0, 4'h0, 32'h0, 4'h0, 0);
    run_cmd(0, 4'h4, 32'h0, 4'h0, 0);
    // back-to-back with rsp_ready tied high
    rsp_tie = 1; rsp_ready = 1;
    run_cmd(1, 4'h8, 32'h0BAD_F00D, 4'hF, 0);
    run_cmd(1, 4'h8, 32'h1100_2200, 4'h6, 0);
    run_cmd(0, 4'h8, 32'h0, 4'h0, 0);
    rsp_tie = 0; rsp_ready = 0;
    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom); r_resp_cfg = 2'($urandom);
      run_cmd(1'($urandom), 4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2));
    end
    chk("payload_stable_end", unstable, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mm_axi_lite_master.md
# mm_axi_lite_master

Single-outstanding AXI4-Lite initiator. It turns one command at a time (read or write, address, data, strobes) from a valid/ready command port into an AXI4-Lite transaction. The AXI response is returned on a valid/ready response port. It drives `mm_axi_ssd` and other register slaves from hardware sequencers and self-test logic without the PS.

## Interface
Reset is asynchronous, active-low. Single clock.

**Parameters**
- `C_M0_axi_DATA_WIDTH`, default 32: AXI data width. Must be 32 or 64.
- `C_M0_axi_ADDR_WIDTH`, default 4: AXI address width.

**Ports**
- `M0_axi_aclk`, in, 1: the single clock. All logic is on its rising edge.
- `M0_axi_aresetn`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: block is able to accept a command.
- `cmd_write`, in, 1: 1 = write, 0 = read.
- `cmd_addr`, in, ADDR_WIDTH: byte address, passed through unchanged.
- `cmd_wdata`, in, DATA_WIDTH: write data.
- `cmd_wstrb`, in, DATA_WIDTH/8: write byte strobes.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_rdata`, out, DATA_WIDTH: read data. Zero for writes.
- `rsp_resp`, out, 2: captured BRESP or RRESP.
- `M0_axi_awaddr`, `M0_axi_awprot`, `M0_axi_awvalid`, out, ADDR_WIDTH / 3 / 1: write address channel.
- `M0_axi_awready`, in, 1.
- `M0_axi_wdata`, `M0_axi_wstrb`, `M0_axi_wvalid`, out, DATA_WIDTH / DATA_WIDTH/8 / 1: write data channel.
- `M0_axi_wready`, in, 1.
- `M0_axi_bresp`, `M0_axi_bvalid`, in, 2 / 1: write response channel.
- `M0_axi_bready`, out, 1.
- `M0_axi_araddr`, `M0_axi_arprot`, `M0_axi_arvalid`, out, ADDR_WIDTH / 3 / 1: read address channel.
- `M0_axi_arready`, in, 1.
- `M0_axi_rdata`, `M0_axi_rresp`, `M0_axi_rvalid`, in, DATA_WIDTH / 2 / 1: read data channel.
- `M0_axi_rready`, out, 1.

## Operation

**FSM states:** IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA, RSP.

**IDLE**
- `cmd_ready` = 1, decoded from state.
- A command is accepted on `cmd_valid & cmd_ready`. On acceptance, latch addr/wdata/wstrb into the AXI payload registers.
- Write command: go to WADDR, setting `awvalid` = `wvalid` = 1.
- Read command: go to RADDR, setting `arvalid` = 1.

**WADDR**
- `awvalid` and `wvalid` each clear independently on their own handshake.
- When both handshakes are complete (possibly in the same cycle), go to WRESP.

**WRESP**
- `bready` = 1.
- On `bvalid`, capture `bresp` into `rsp_resp`, set `rsp_rdata` = 0, and go to RSP.

**RADDR**
- `arvalid` clears on `arready`, then go to RDATA.

**RDATA**
- `rready` = 1.
- On `rvalid`, capture `rdata`/`rresp` and go to RSP.

**RSP**
- `rsp_valid` = 1, with payload held stable.
- On `rsp_ready`, go to IDLE.

**Protocol rules**
- `awprot` = `arprot` = 3'b000, constant.
- `bready`/`rready` are asserted only in WRESP/RDATA.
- `bvalid`/`rvalid` in any other state are ignored.
- No valid output depends combinationally on any AXI ready.
- Once a valid is asserted, it and its payload stay stable until the handshake.

## Timing

**Reset values:** all of the following are 0:
- `awvalid`, `wvalid`, `arvalid`, `bready`, `rready`, `rsp_valid`
- `awaddr`, `araddr`, `wdata`, `wstrb`, `rsp_rdata`, `rsp_resp`

`cmd_ready` is 1 once reset is released (state = IDLE).

**Latency** (command accepted at edge N):
- AXI valids rise in cycle N+1.
- With a zero-wait slave: handshake at N+1, B/R at N+2, and `rsp_valid` in cycle N+3.
- Each slave wait cycle adds 1.

**Response handshake and throughput**
- If `rsp_ready` is high in the first RSP cycle, `cmd_ready` is 1 the next cycle.
- Peak throughput is one command per 4 cycles.
- `cmd_valid` while not in IDLE is ignored (not latched).

**Reset mid-transaction**
- All outputs clear asynchronously and the state returns to IDLE.
- The in-flight transaction is abandoned, with no response.

**Simultaneous events**
- An AW and W handshake in the same cycle goes directly to WRESP.
- `rsp_valid` and `rsp_ready` asserted in the same cycle complete the handshake.

## Test plan
1. **Zero-wait write.** Write addr 0x4, data 0x0000_1234, strb 0xF; slave always ready, bresp 00.
   - `awvalid`/`wvalid` are high for exactly 1 cycle.
   - `rsp_valid` at N+3 with resp 00, rdata 0.
2. **Delayed AW.** `awready` delayed 3 cycles, `wready` immediate.
   - `wvalid` drops after 1 cycle.
   - `awvalid` is held 4 cycles with `awaddr` stable.
   - Exactly one B handshake.
3. **Read with error and wait.** Read addr 0x8; `rvalid` arrives 5 cycles after the AR handshake with rdata 0xDEAD_BEEF, rresp 10.
   - `rsp_rdata` = 0xDEAD_BEEF, `rsp_resp` = 10.
4. **Response backpressure.** `rsp_ready` held low 10 cycles.
   - `rsp_valid` and payload stay stable.
   - `cmd_ready` = 0.
   - A concurrent `cmd_valid` is not accepted.
5. **Reset mid-write.** `M0_axi_aresetn` pulsed low while `awvalid` = 1.
   - All valids drop without waiting for a clock edge.
   - After release, `cmd_ready` = 1, and a subsequent read of 0x0 completes normally.
6. **Back-to-back.** Two writes then a read, with `rsp_ready` tied 1.
   - Each command is accepted on the cycle after the previous `rsp_valid`.
   - Responses arrive in order.
